// File: rtl/regfile_wb_unit_if.sv
// Result and scoreboard bus between the EX/MEM result producers, decode and
// the GPR write-port merger.
interface regfile_wb_unit_if #(
    parameter int unsigned REG_NUM = 32
);
    localparam int unsigned AW = $clog2(REG_NUM);
    localparam int unsigned DW = 32;

    logic          a_valid;
    logic [AW-1:0] a_waddr;
    logic [DW-1:0] a_wdata;

    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_waddr;
    logic [DW-1:0] b_wdata;

    logic          alloc_valid;
    logic [AW-1:0] alloc_addr;

    logic [AW-1:0] query_addr1;
    logic [AW-1:0] query_addr2;
    logic          busy1;
    logic          busy2;

    logic          gpr_we;
    logic [AW-1:0] gpr_waddr;
    logic [DW-1:0] gpr_wdata;

    logic          sb_err;

    // Producer / decode / regfile side
    modport master (
        output a_valid, a_waddr, a_wdata,
        output b_valid, b_waddr, b_wdata,
        output alloc_valid, alloc_addr,
        output query_addr1, query_addr2,
        input  b_ready, busy1, busy2,
        input  gpr_we, gpr_waddr, gpr_wdata,
        input  sb_err
    );

    // Write-back unit side
    modport slave (
        input  a_valid, a_waddr, a_wdata,
        input  b_valid, b_waddr, b_wdata,
        input  alloc_valid, alloc_addr,
        input  query_addr1, query_addr2,
        output b_ready, busy1, busy2,
        output gpr_we, gpr_waddr, gpr_wdata,
        output sb_err
    );
endinterface

// File: rtl/regfile_wb_unit.sv
// GPR write-port merger: single-cycle results (A) beat buffered long-latency
// results (B); a pending scoreboard lets decode stall on long-latency targets.
module regfile_wb_unit #(
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    regfile_wb_unit_if.slave wb
);
    localparam int unsigned AW = $clog2(REG_NUM);
    localparam int unsigned DW = 32;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    wb_entry_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    wb_entry_t          head;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;

    logic               sel_valid;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_data;

    logic [REG_NUM-1:0] pending;
    logic [REG_NUM-1:0] pending_nxt;
    logic               sb_err_q;
    logic               sb_err_set;

    logic               gpr_we_q;
    logic [AW-1:0]      gpr_waddr_q;
    logic [DW-1:0]      gpr_wdata_q;

    // FIFO status from registered count only; a full FIFO never passes through
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr];
    assign push       = wb.b_valid && !fifo_full;
    assign pop        = !wb.a_valid && !fifo_empty;

    // Fixed priority A over buffered B
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        if (wb.a_valid) begin
            sel_valid = 1'b1;
            sel_addr  = wb.a_waddr;
            sel_data  = wb.a_wdata;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_addr  = head.addr;
            sel_data  = head.data;
        end
    end

    // Storage needs no reset: occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wb_entry_t'{addr: wb.b_waddr, data: wb.b_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Pop clears, alloc sets (set wins); re-alloc of a still-pending target is an error
    always_comb begin
        pending_nxt = pending;
        sb_err_set  = 1'b0;
        if (pop) begin
            pending_nxt[head.addr] = 1'b0;
        end
        if (wb.alloc_valid && (wb.alloc_addr != '0)) begin
            if (pending_nxt[wb.alloc_addr]) begin
                sb_err_set = 1'b1;
            end
            pending_nxt[wb.alloc_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending  <= '0;
            sb_err_q <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (sb_err_set) begin
                sb_err_q <= 1'b1;
            end
        end
    end

    // Register-0 writes are consumed without asserting the write enable
    always_ff @(posedge clk) begin
        if (!rst) begin
            gpr_we_q    <= 1'b0;
            gpr_waddr_q <= '0;
            gpr_wdata_q <= '0;
        end else if (sel_valid) begin
            gpr_we_q    <= (sel_addr != '0);
            gpr_waddr_q <= sel_addr;
            gpr_wdata_q <= sel_data;
        end else begin
            gpr_we_q    <= 1'b0;
        end
    end

    assign wb.b_ready   = !fifo_full;
    assign wb.busy1     = pending[wb.query_addr1];
    assign wb.busy2     = pending[wb.query_addr2];
    assign wb.gpr_we    = gpr_we_q;
    assign wb.gpr_waddr = gpr_waddr_q;
    assign wb.gpr_wdata = gpr_wdata_q;
    assign wb.sb_err    = sb_err_q;

endmodule

// File: tb/tb_regfile_wb_unit.sv
// Self-checking bench for regfile_wb_unit: directed scenarios plus random
// traffic compared against a queue/array reference model.
module tb_regfile_wb_unit;
    localparam int REG_NUM = 32;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_unit_if #(.REG_NUM(REG_NUM)) wbif ();

    regfile_wb_unit #(.REG_NUM(REG_NUM), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wbif)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        fq[$];
    bit          mp[REG_NUM];
    bit          m_sb;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_pushed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one posedge worth of behaviour
    task automatic model_edge();
        ent_t e;
        bit   ready;
        bit   sv;
        logic [4:0]  sa;
        logic [31:0] sd;
        m_pushed = 0;
        if (rst == 1'b0) begin
            fq.delete();
            foreach (mp[i]) mp[i] = 0;
            m_sb = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
            return;
        end
        ready = (fq.size() < DEPTH);
        sv = 0; sa = '0; sd = '0;
        if (wbif.a_valid) begin
            sv = 1; sa = wbif.a_waddr; sd = wbif.a_wdata;
        end else if (fq.size() > 0) begin
            e  = fq.pop_front();
            sv = 1; sa = e.addr; sd = e.data;
            mp[e.addr] = 0;
        end
        m_we = sv && (sa != 5'd0);
        if (sv) begin
            m_waddr = sa; m_wdata = sd;
        end
        if (wbif.b_valid && ready) begin
            e.addr = wbif.b_waddr; e.data = wbif.b_wdata;
            fq.push_back(e);
            m_pushed = 1;
        end
        if (wbif.alloc_valid && wbif.alloc_addr != 5'd0) begin
            if (mp[wbif.alloc_addr]) m_sb = 1;
            mp[wbif.alloc_addr] = 1;
        end
        mp[0] = 0;
    endtask

    task automatic idle();
        wbif.a_valid = 0; wbif.a_waddr = '0; wbif.a_wdata = '0;
        wbif.b_valid = 0; wbif.b_waddr = '0; wbif.b_wdata = '0;
        wbif.alloc_valid = 0; wbif.alloc_addr = '0;
    endtask

    // Check combinational outputs before the edge, registered ones after it
    task automatic cycle();
        #1;
        chk("b_ready", 32'(wbif.b_ready), 32'(fq.size() < DEPTH));
        chk("busy1", 32'(wbif.busy1), 32'(mp[wbif.query_addr1]));
        chk("busy2", 32'(wbif.busy2), 32'(mp[wbif.query_addr2]));
        @(posedge clk);
        model_edge();
        #1;
        chk("gpr_we", 32'(wbif.gpr_we), 32'(m_we));
        if (m_we) begin
            chk("gpr_waddr", 32'(wbif.gpr_waddr), 32'(m_waddr));
            chk("gpr_wdata", wbif.gpr_wdata, m_wdata);
        end
        chk("sb_err", 32'(wbif.sb_err), 32'(m_sb));
    endtask

    function automatic logic [4:0] pick_free();
        logic [4:0] r;
        for (int i = 0; i < 32; i++) begin
            r = 5'($urandom_range(0, REG_NUM - 1));
            if (!mp[r]) return r;
        end
        return 5'd0;
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        wbif.query_addr1 = '0;
        wbif.query_addr2 = '0;
        @(posedge clk);
        model_edge();
        #1;

        // Reset held with traffic present
        wbif.a_valid = 1; wbif.a_waddr = 5'd5; wbif.a_wdata = 32'hDEADBEEF;
        wbif.b_valid = 1; wbif.b_waddr = 5'd6; wbif.b_wdata = 32'h66;
        repeat (2) begin
            cycle();
            chk("rst_we", 32'(wbif.gpr_we), 32'd0);
            chk("rst_ready", 32'(wbif.b_ready), 32'd1);
            chk("rst_busy", 32'({wbif.busy1, wbif.busy2}), 32'd0);
            chk("rst_sb", 32'(wbif.sb_err), 32'd0);
        end
        chk("rst_waddr", 32'(wbif.gpr_waddr), 32'd0);
        chk("rst_wdata", wbif.gpr_wdata, 32'd0);

        // Port A write, latency one
        rst = 1'b1;
        wbif.b_valid = 0;
        cycle();
        chk("a_we", 32'(wbif.gpr_we), 32'd1);
        chk("a_waddr", 32'(wbif.gpr_waddr), 32'd5);
        chk("a_wdata", wbif.gpr_wdata, 32'hDEADBEEF);
        wbif.a_waddr = 5'd0; wbif.a_wdata = 32'h12345678;
        cycle();
        chk("a_zero_we", 32'(wbif.gpr_we), 32'd0);

        // Priority and fill: A keeps the FIFO from draining
        wbif.a_waddr = 5'd20; wbif.a_wdata = 32'hA0A0A0A0;
        wbif.b_valid = 1; wbif.b_waddr = 5'd1; wbif.b_wdata = 32'h101;
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (m_pushed && wbif.b_waddr < 5'd5) begin
                wbif.b_waddr = wbif.b_waddr + 5'd1;
                wbif.b_wdata = 32'h100 + 32'(wbif.b_waddr);
            end
        end
        chk("fill_ready", 32'(wbif.b_ready), 32'd0);
        wbif.a_valid = 0;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            if (m_pushed) wbif.b_valid = 0;
            chk("drain_we", 32'(wbif.gpr_we), 32'd1);
            chk("drain_addr", 32'(wbif.gpr_waddr), 32'(i));
            chk("drain_data", wbif.gpr_wdata, 32'h100 + 32'(i));
            if (i == 1) chk("drain_ready", 32'(wbif.b_ready), 32'd1);
        end
        idle();
        cycle();

        // Scoreboard: alloc r7, then B result for r7
        wbif.alloc_valid = 1; wbif.alloc_addr = 5'd7; wbif.query_addr1 = 5'd7;
        cycle();
        chk("sb_busy_set", 32'(wbif.busy1), 32'd1);
        wbif.alloc_valid = 0;
        wbif.b_valid = 1; wbif.b_waddr = 5'd7; wbif.b_wdata = 32'h1234;
        cycle();
        chk("sb_busy_queued", 32'(wbif.busy1), 32'd1);
        wbif.b_valid = 0;
        cycle();
        chk("sb_busy_clr", 32'(wbif.busy1), 32'd0);
        chk("sb_we", 32'(wbif.gpr_we), 32'd1);
        chk("sb_waddr", 32'(wbif.gpr_waddr), 32'd7);
        chk("sb_wdata", wbif.gpr_wdata, 32'h1234);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            wbif.a_valid     = ($urandom_range(0, 99) < 35);
            wbif.a_waddr     = pick_free();
            wbif.a_wdata     = $urandom;
            wbif.b_valid     = 1'($urandom_range(0, 1));
            wbif.b_waddr     = 5'($urandom_range(0, REG_NUM - 1));
            wbif.b_wdata     = $urandom;
            wbif.alloc_valid = ($urandom_range(0, 9) == 0);
            wbif.alloc_addr  = 5'($urandom_range(0, REG_NUM - 1));
            wbif.query_addr1 = 5'($urandom_range(0, REG_NUM - 1));
            wbif.query_addr2 = 5'($urandom_range(0, REG_NUM - 1));
            cycle();
        end

        // Fresh reset, then set/clear collision on r9
        idle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        wbif.query_addr1 = 5'd9; wbif.query_addr2 = 5'd3;
        wbif.alloc_valid = 1; wbif.alloc_addr = 5'd9;
        cycle();
        wbif.alloc_valid = 0;
        wbif.b_valid = 1; wbif.b_waddr = 5'd9; wbif.b_wdata = 32'h99;
        cycle();
        wbif.b_valid = 0;
        wbif.alloc_valid = 1; wbif.alloc_addr = 5'd9;
        cycle();
        chk("coll_busy", 32'(wbif.busy1), 32'd1);
        chk("coll_sb", 32'(wbif.sb_err), 32'd0);
        chk("coll_we", 32'(wbif.gpr_we), 32'd1);
        cycle();
        chk("dup_sb", 32'(wbif.sb_err), 32'd1);
        wbif.alloc_valid = 0;
        repeat (3) cycle();
        chk("sticky_sb", 32'(wbif.sb_err), 32'd1);

        // Reset with three queued entries and r3 pending
        wbif.a_valid = 1; wbif.a_waddr = 5'd20; wbif.a_wdata = 32'h5A5A5A5A;
        wbif.alloc_valid = 1; wbif.alloc_addr = 5'd3;
        wbif.b_valid = 1;
        for (int i = 0; i < 3; i++) begin
            wbif.b_waddr = 5'(10 + i); wbif.b_wdata = 32'(i);
            cycle();
            wbif.alloc_valid = 0;
        end
        chk("pre_rst_busy3", 32'(wbif.busy2), 32'd1);
        idle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("post_rst_we", 32'(wbif.gpr_we), 32'd0);
            chk("post_rst_ready", 32'(wbif.b_ready), 32'd1);
            chk("post_rst_busy3", 32'(wbif.busy2), 32'd0);
            chk("post_rst_sb", 32'(wbif.sb_err), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_unit.md
Name: regfile_wb_unit

Overview:
- Writer side of the GPR write port: merges single-cycle pipeline results (port A) and long-latency results such as loads or mul/div (port B) onto the one regfile write port (gpr_we/gpr_waddr/gpr_wdata).
- Port B results pass through a small FIFO.
- Holds a pending-write scoreboard that decode queries to stall on long-latency destinations.
- Sits between the EX/MEM result buses and regfile.

Parameters:
- REG_NUM, 32, number of GPRs; address width is log2(REG_NUM).
- FIFO_DEPTH, 4, port B buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-low reset; sampled on posedge clk, reset when 0.
- a_valid  in  1  port A result valid; always accepted, no ready.
- a_waddr  in  5  port A destination.
- a_wdata  in  32  port A data.
- b_valid  in  1  port B result valid.
- b_ready  out  1  port B accept; transfer when b_valid && b_ready.
- b_waddr  in  5  port B destination.
- b_wdata  in  32  port B data.
- alloc_valid  in  1  long-latency op issued; mark its destination pending.
- alloc_addr  in  5  destination to mark.
- query_addr1  in  5  decode source 1.
- query_addr2  in  5  decode source 2.
- busy1  out  1  pending[query_addr1]; combinational.
- busy2  out  1  pending[query_addr2]; combinational.
- gpr_we  out  1  regfile write enable; registered.
- gpr_waddr  out  5  regfile write address; registered.
- gpr_wdata  out  32  regfile write data; registered.
- sb_err  out  1  sticky: alloc to an address already pending.

Behaviour:
- Reset (rst==0 at posedge):
  - gpr_we=0, gpr_waddr=0, gpr_wdata=0.
  - FIFO empty (rd/wr pointers 0, count 0); pending all 0; sb_err=0.
  - Reset mid-operation discards FIFO contents and pending bits, with no write emitted.
- FIFO:
  - b_ready = (count != FIFO_DEPTH), computed from current state only.
  - When full, push is refused even if a pop occurs in the same cycle (no pass-through).
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
- Arbitration (each cycle):
  - If a_valid: select A; the FIFO head waits.
  - Else if FIFO non-empty: select head and pop it.
  - Else: nothing selected.
  - Fixed priority A > B. Starvation of B is acceptable: the pipeline guarantees A bubbles.
- Output register:
  - The selected write appears on gpr_we/gpr_waddr/gpr_wdata in the next cycle (latency 1).
  - With nothing selected, gpr_we=0; waddr/wdata hold their previous values.
- Address 0:
  - A selected write with waddr==0 is consumed (a B entry is still popped) but produces gpr_we=0.
  - alloc_addr==0 never sets a pending bit; pending[0] is constant 0.
- Scoreboard:
  - On the posedge where a B entry with waddr=r is popped, pending[r] clears. busy drops in the same cycle gpr_we=1 for r, and regfile bypass supplies the data.
  - alloc_valid sets pending[alloc_addr] at posedge.
  - Set and clear of the same address in the same cycle: set wins.
  - alloc to an already-pending address: pending stays 1 and sb_err sets; sb_err clears only on reset.
  - Port A writes never touch pending. Issue logic guarantees no A write to a pending address (no WAW).
- busy1/busy2 reflect registered pending bits only; no same-cycle alloc forwarding.

Test Plan:
- Reset: hold rst=0 for 2 cycles with b_valid=1, a_valid=1 -> gpr_we=0, b_ready=1, busy1=busy2=0, sb_err=0; release -> first write appears 1 cycle later.
- Port A only: a_valid=1, a_waddr=5, a_wdata=0xDEADBEEF at cycle t -> gpr_we=1, gpr_waddr=5, gpr_wdata=0xDEADBEEF at t+1; a_waddr=0 -> gpr_we=0.
- Priority/fill: a_valid=1 continuously while pushing 5 B writes to r1..r5 -> b_ready=0 after 4 accepts. Drop a_valid -> gpr writes r1,r2,r3,r4 in consecutive cycles, then r5; b_ready returns 1 the cycle after the first pop.
- Scoreboard: alloc r7; query_addr1=7 -> busy1=1. B write r7=0x1234 -> busy1=0 in the same cycle gpr_we=1, gpr_waddr=7.
- Set/clear collision: B r9 popped in the same cycle as alloc r9 -> pending[9] stays 1, sb_err=0. Then alloc r9 again while pending -> sb_err=1 and stays 1.
- Reset mid-operation: 3 entries in FIFO, pending r3 set, assert rst=0 -> no further gpr_we, FIFO count 0, busy for r3 = 0.
